mdu_seq_ctrl: RTL and testbench

//  Multiply/divide sequencer for the pipelined MIPS core (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//  - Has no adder of its own: drives the shared ALU (add/sub path) one step per cycle over a
//    req/gnt handshake, and keeps working registers.
//  - Owns the architectural HI/LO registers.
//  - Sits beside EX; the hazard unit stalls on busy.

---
 rtl/mdu_seq_ctrl_pkg.sv | 33 +++
 rtl/mdu_seq_ctrl_step.sv | 53 +++++
 rtl/mdu_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, ALU function codes
// and FSM states.
package mdu_seq_ctrl_pkg;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam logic [5:0] AluAdd = 6'b000000;
  localparam logic [5:0] AluSub = 6'b000001;

  typedef enum logic [2:0] {
    StIdle,
    StSignA,
    StSignB,
    StIter,
    StFixLo,
    StFixHi,
    StDone
  } state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_step.sv
// One shift-add multiply or restoring-divide iteration: picks the shared ALU operands and
// folds the ALU result back into the next {W_HI, W_LO}.
module mdu_seq_ctrl_step
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] w_hi,
  input  logic [DATA_W-1:0] w_lo,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] divisor,
  input  logic [DATA_W-1:0] alu_s,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fun,
  output logic [DATA_W-1:0] w_hi_nxt,
  output logic [DATA_W-1:0] w_lo_nxt
);

  logic [DATA_W-1:0] t;
  logic              carry;
  logic              ge;

  assign t     = {w_hi[DATA_W-2:0], w_lo[DATA_W-1]};
  // W_HI[msb] is the 33rd bit of the shifted partial remainder, so it forces a subtract.
  assign ge    = w_hi[DATA_W-1] | (t >= divisor);
  assign carry = alu_s < w_hi;

  // Operand select is kept apart from the result path so alu_s never loops back into alu_a/b.
  always_comb begin
    if (is_div) begin
      alu_a   = t;
      alu_b   = divisor;
      alu_fun = AluSub;
    end else begin
      alu_a   = w_hi;
      alu_b   = w_lo[0] ? mcand : '0;
      alu_fun = AluAdd;
    end
  end

  always_comb begin
    if (is_div) begin
      w_hi_nxt = ge ? alu_s : t;
      w_lo_nxt = {w_lo[DATA_W-2:0], ge};
    end else begin
      w_hi_nxt = {carry, alu_s[DATA_W-1:1]};
      w_lo_nxt = {alu_s[0], w_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multiply/divide sequencer: borrows the shared ALU one step per granted cycle and owns
// the architectural HI/LO registers.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fun,
  output logic              alu_sign,
  input  logic [DATA_W-1:0] alu_s
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] w_hi_q, w_hi_d, w_lo_q, w_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              sa_q, sa_d, sb_q, sb_d, z_q, z_d;
  logic              div_q, div_d, sgn_q, sgn_d;

  logic [DATA_W-1:0] step_a, step_b, w_hi_nxt, w_lo_nxt;
  logic [5:0]        step_fun;
  logic [DATA_W-1:0] mag, fix_hi;
  logic              gnt;

  mdu_seq_ctrl_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .is_div   (div_q),
    .w_hi     (w_hi_q),
    .w_lo     (w_lo_q),
    .mcand    (a_q),
    .divisor  (b_q),
    .alu_s    (alu_s),
    .alu_a    (step_a),
    .alu_b    (step_b),
    .alu_fun  (step_fun),
    .w_hi_nxt (w_hi_nxt),
    .w_lo_nxt (w_lo_nxt)
  );

  assign busy     = !(state_q inside {StIdle, StDone});
  assign alu_req  = busy;
  assign done     = (state_q == StDone);
  assign alu_sign = 1'b0;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign gnt      = alu_req & alu_gnt;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = AluSub;
    unique case (state_q)
      StSignA: alu_b = a_q;
      StSignB: alu_b = b_q;
      StIter: begin
        alu_a   = step_a;
        alu_b   = step_b;
        alu_fun = step_fun;
      end
      StFixLo: alu_b = w_lo_q;
      StFixHi: begin
        if (div_q) begin
          alu_b = w_hi_q;
        end else begin
          // Two's-complement carry from the low word: -{H,L} = {~H + (L==0), -L}.
          alu_a   = ~w_hi_q;
          alu_b   = {{(DATA_W-1){1'b0}}, z_q};
          alu_fun = AluAdd;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    w_hi_d  = w_hi_q;
    w_lo_d  = w_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    z_d     = z_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    mag     = '0;
    fix_hi  = '0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          case (op)
            OpMthi: hi_d = rs_val;
            OpMtlo: lo_d = rs_val;
            OpMult, OpMultu, OpDiv, OpDivu: begin
              div_d  = is_div_op(op);
              sgn_d  = is_signed_op(op);
              a_d    = rs_val;
              b_d    = rt_val;
              cnt_d  = '0;
              w_hi_d = '0;
              w_lo_d = is_div_op(op) ? rs_val : rt_val;
              if (is_div_op(op) && (rt_val == '0)) begin
                w_hi_d  = rs_val;
                w_lo_d  = '1;
                hi_d    = rs_val;
                lo_d    = '1;
                state_d = StDone;
              end else begin
                state_d = is_signed_op(op) ? StSignA : StIter;
              end
            end
            default: ;
          endcase
        end
      end
      StSignA: begin
        if (gnt) begin
          a_d     = a_q[DATA_W-1] ? alu_s : a_q;
          sa_d    = a_q[DATA_W-1];
          state_d = StSignB;
        end
      end
      StSignB: begin
        mag = b_q[DATA_W-1] ? alu_s : b_q;
        if (gnt) begin
          b_d     = mag;
          sb_d    = b_q[DATA_W-1];
          w_lo_d  = div_q ? a_q : mag;
          state_d = StIter;
        end
      end
      StIter: begin
        if (gnt) begin
          w_hi_d = w_hi_nxt;
          w_lo_d = w_lo_nxt;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = '0;
            if (sgn_q) begin
              state_d = StFixLo;
            end else begin
              hi_d    = w_hi_nxt;
              lo_d    = w_lo_nxt;
              state_d = StDone;
            end
          end
        end
      end
      StFixLo: begin
        if (gnt) begin
          if (sa_q ^ sb_q) w_lo_d = alu_s;
          z_d     = (w_lo_q == '0);
          state_d = StFixHi;
        end
      end
      StFixHi: begin
        // Remainder takes the dividend's sign; the product high word takes sa^sb.
        fix_hi = (div_q ? sa_q : (sa_q ^ sb_q)) ? alu_s : w_hi_q;
        if (gnt) begin
          w_hi_d  = fix_hi;
          hi_d    = fix_hi;
          lo_d    = w_lo_q;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      w_hi_q  <= '0;
      w_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      z_q     <= 1'b0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_hi_q  <= w_hi_d;
      w_lo_q  <= w_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      z_q     <= z_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: arithmetic reference model with per-cycle output compare, plus
// directed operations with literal results and completion cycles.
`timescale 1ns/1ps
module tb_mdu_seq_ctrl;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  logic        clk = 1'b0;
  logic        reset, start, alu_gnt;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, alu_req, alu_sign;
  logic [31:0] hi, lo, alu_a, alu_b, alu_s;
  logic [5:0]  alu_fun;

  int checks = 0;
  int failures = 0;

  mdu_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .alu_req  (alu_req),
    .alu_gnt  (alu_gnt),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_fun  (alu_fun),
    .alu_sign (alu_sign),
    .alu_s    (alu_s)
  );

  // Shared ALU stand-in: combinational add/sub, garbage for any other function code.
  assign alu_s = (alu_fun == 6'b000000) ? alu_a + alu_b :
                 (alu_fun == 6'b000001) ? alu_a - alu_b : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OpMult:  r = 64'(sa * sb);
      OpMultu: r = {32'd0, a} * {32'd0, b};
      OpDiv:   r = {32'(sa % sb), 32'(sa / sb)};
      default: r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // Model: an op needs a fixed number of granted ALU steps, then commits {hi,lo}.
  int          m_steps;
  bit          m_done;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_steps <= 0;
      m_done  <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_phi   <= '0;
      m_plo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_steps > 0) begin
        if (alu_gnt) begin
          m_steps <= m_steps - 1;
          if (m_steps == 1) begin
            m_done <= 1'b1;
            m_hi   <= m_phi;
            m_lo   <= m_plo;
          end
        end
      end else if (start) begin
        if (op == OpMthi) m_hi <= rs_val;
        else if (op == OpMtlo) m_lo <= rs_val;
        else if (op == OpMult || op == OpMultu || op == OpDiv || op == OpDivu) begin
          if ((op == OpDiv || op == OpDivu) && rt_val == 0) begin
            m_done <= 1'b1;
            m_hi   <= rs_val;
            m_lo   <= 32'hFFFF_FFFF;
          end else begin
            {m_phi, m_plo} <= ref_result(op, rs_val, rt_val);
            m_steps <= (op == OpMult || op == OpDiv) ? 36 : 32;
          end
        end
      end
    end
  end

  logic [31:0] p_a, p_b;
  logic [5:0]  p_fun;
  bit          p_stall = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("busy", busy, m_steps > 0);
      chk("alu_req", alu_req, m_steps > 0);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("alu_sign", alu_sign, 1'b0);
      if (p_stall) begin
        chk("alu_a stable", alu_a, p_a);
        chk("alu_b stable", alu_b, p_b);
        chk("alu_fun stable", alu_fun, p_fun);
      end
      p_stall <= alu_req && !alu_gnt;
      p_a     <= alu_a;
      p_b     <= alu_b;
      p_fun   <= alu_fun;
    end else begin
      p_stall <= 1'b0;
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int st_lo, input int st_hi, input int exp_cyc,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    bit seen_req = 1'b0;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    start   = 1'b1;
    op      = o;
    rs_val  = a;
    rt_val  = b;
    alu_gnt = !(st_lo <= 0 && 0 <= st_hi);
    @(negedge clk);
    if (alu_req) seen_req = 1'b1;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      alu_gnt = !(st_lo <= c && c <= st_hi);
      @(negedge clk);
      if (alu_req) seen_req = 1'b1;
      if (done) begin
        got = 1'b1;
        chk({name, " done cycle"}, 64'(c), 64'(exp_cyc));
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
      end
    end
    alu_gnt = 1'b1;
    if (!got) chk({name, " done seen"}, 0, 1);
    if (exp_cyc == 1) chk({name, " alu_req never"}, seen_req, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    rs_val  = '0;
    rt_val  = '0;
    alu_gnt = 1'b1;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset alu_req", alu_req, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;

    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 33, 32'hFFFF_FFFE, 32'h1, "multu_max");
    run_op(OpMult, 32'hFFFF_FFFD, 32'd7, -1, -1, 37, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, -1, -1, 37, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(OpDivu, 32'd100, 32'd7, -1, -1, 33, 32'd2, 32'd14, "divu_100_7");
    run_op(OpDivu, 32'd5, 32'd0, -1, -1, 1, 32'd5, 32'hFFFF_FFFF, "divu_by0");
    run_op(OpMultu, 32'd3, 32'd5, 5, 14, 43, 32'd0, 32'd15, "multu_stall");
    run_op(OpMult, 32'hFFFF_FFFB, 32'hFFFF_FFFA, -1, -1, 37, 32'd0, 32'd30, "mult_negneg");
    run_op(OpMult, 32'h8000_0000, 32'd2, -1, -1, 37, 32'hFFFF_FFFF, 32'd0, "mult_lo_zero");
    run_op(OpMult, 32'hFFFF_FFFD, 32'd7, 1, 3, 40, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_sstall");
    run_op(OpDiv, 32'hFFFF_FFF8, 32'd0, -1, -1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_by0");
    run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, -1, -1, 37, 32'd1, 32'hFFFF_FFFD, "div_negdvsr");

    // Asynchronous reset in the middle of a MULT.
    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = OpMult;
    rs_val = 32'hFFFF_FFFD;
    rt_val = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst alu_req", alu_req, 0);
    chk("async rst done", done, 0);
    chk("async rst hi", hi, 0);
    chk("async rst lo", lo, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;

    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = OpMthi;
    rs_val = 32'h0000_1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("mthi hi", hi, 32'h0000_1234);
    chk("mthi lo", lo, 32'h0);
    chk("mthi busy", busy, 0);
    chk("mthi done", done, 0);

    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = OpMtlo;
    rs_val = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("mtlo lo", lo, 32'hCAFE_0001);
    chk("mtlo hi", hi, 32'h0000_1234);
    chk("mtlo busy", busy, 0);

    // Unused op code must leave everything untouched.
    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = 3'b111;
    rs_val = 32'h5555_5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("nop busy", busy, 0);
    chk("nop hi", hi, 32'h0000_1234);
    chk("nop lo", lo, 32'hCAFE_0001);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
